sync_fifo: RTL

Single-clock first-word-fall-through FIFO that sits directly downstream of the UART receiver. It absorbs received words on the receiver's `we`/`dout` strobe and returns `full` for the receiver's own gating. It presents the head word to the consuming logic (command parser / loopback TX) with a pop handshake. Level flags, an occupancy count and sticky error flags support flow control and debug.

---
 rtl/uart_pkg.sv | 8 +
 rtl/sync_fifo_if.sv | 33 +++
 rtl/fifo_mem.sv | 32 +++
 rtl/sync_fifo.sv | 103 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Defaults shared by the UART receive path, the receive FIFO and the TX path.
// Word width and FIFO depth live here so every block agrees on them.
package uart_pkg;

  localparam int UART_WORD_WIDTH = 8;
  localparam int UART_DEPTH_LOG2 = 4;

endpackage : uart_pkg

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a word producer/consumer and sync_fifo.
// master = the logic around the FIFO, slave = the FIFO itself.
interface sync_fifo_if
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH = UART_WORD_WIDTH,
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) ();

  logic [WORD_WIDTH-1:0] din;
  logic                  we;
  logic                  full;
  logic [WORD_WIDTH-1:0] dout;
  logic                  re;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output din, we, re, clr_err,
    input  full, dout, empty, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  din, we, re, clr_err,
    output full, dout, empty, count, almost_full, almost_empty, overflow, underflow
  );

endinterface : sync_fifo_if

// File: rtl/fifo_mem.sv
// DEPTH x WORD_WIDTH storage: one synchronous write port, one asynchronous
// read port, so it maps onto distributed RAM.
module fifo_mem
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH = UART_WORD_WIDTH,
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose -- a reset port would stop it
  // mapping to RAM, and stale words are never visible because dout is masked
  // while empty. Non-blocking assignment keeps the write ordered after reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO behind the UART receiver: pointer, occupancy,
// level-flag and sticky-error logic around a fifo_mem storage array.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH   = UART_WORD_WIDTH,
  parameter int DEPTH_LOG2   = UART_DEPTH_LOG2,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic          AF_RST    = (ALMOST_FULL <= 0);
  localparam logic          AE_RST    = (ALMOST_EMPTY >= 0);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  ae_q;
  logic                  of_q;
  logic                  uf_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [WORD_WIDTH-1:0] mem_rdata;

  // Acceptance uses only registered flags, so a pop never frees room for a
  // write in the same cycle and an empty FIFO never bypasses din to dout.
  assign wr_acc = bus.we && !full_q;
  assign rd_acc = bus.re && !empty_q;

  // NOTE: count_nxt is given its hold value before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    count_nxt = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= AF_RST;
      ae_q    <= AE_RST;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_CNT);
      empty_q <= (count_nxt == '0);
      af_q    <= (int'(count_nxt) >= ALMOST_FULL);
      ae_q    <= (int'(count_nxt) <= ALMOST_EMPTY);
      // A new error in the same cycle as clr_err wins over the clear.
      of_q    <= (of_q && !bus.clr_err) || (bus.we && full_q);
      uf_q    <= (uf_q && !bus.clr_err) || (bus.re && empty_q);
    end
  end

  fifo_mem #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.din),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  assign bus.dout         = empty_q ? '0 : mem_rdata;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.count        = count_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = of_q;
  assign bus.underflow    = uf_q;

endmodule : sync_fifo
